ariscv_wbq: RTL

Writeback queue feeding the write port (we3/a3/wd3) of the RISC-V general register file. It merges two result producers into the single register-file write port: the ALU, which has fixed latency, priority and no backpressure, and the load/store unit, which uses a valid/ready handshake and is buffered in a small FIFO. It enforces program-order write semantics per destination register. With the forwarding option enabled, it also exposes pending load results so decode can bypass them.

---
 rtl/ariscv_pkg.sv | 15 +
 rtl/ariscv_wbq_if.sv | 32 +++
 rtl/ariscv_wbq_fifo.sv | 86 ++++++++
 rtl/ariscv_wbq.sv | 100 ++++++++++
 4 files changed

// File: rtl/ariscv_pkg.sv
// rtl/ariscv_pkg.sv - shared register-file constants and writeback-queue entry type
package ariscv_pkg;

    localparam int REGW = 32;
    localparam int MSB  = 4;

    localparam logic [MSB:0] ZERO = '0;

    typedef struct packed {
        logic            live;
        logic [MSB:0]    rd;
        logic [REGW-1:0] wd;
    } wbq_ent_t;

endpackage

// File: rtl/ariscv_wbq_if.sv
// rtl/ariscv_wbq_if.sv - ALU/LSU result inputs, register-file write port and forward query
interface ariscv_wbq_if #(parameter int DEPTH = 4);
    import ariscv_pkg::*;

    localparam int OW = $clog2(DEPTH) + 1;

    logic            alu_vld;
    logic [MSB:0]    alu_rd;
    logic [REGW-1:0] alu_wd;
    logic            lsu_vld;
    logic            lsu_rdy;
    logic [MSB:0]    lsu_rd;
    logic [REGW-1:0] lsu_wd;
    logic            we3;
    logic [MSB:0]    a3;
    logic [REGW-1:0] wd3;
    logic [OW-1:0]   occ;
    logic [MSB:0]    fq_a;
    logic            fq_hit;
    logic [REGW-1:0] fq_data;

    modport master (
        output alu_vld, alu_rd, alu_wd, lsu_vld, lsu_rd, lsu_wd, fq_a,
        input  lsu_rdy, we3, a3, wd3, occ, fq_hit, fq_data
    );

    modport slave (
        input  alu_vld, alu_rd, alu_wd, lsu_vld, lsu_rd, lsu_wd, fq_a,
        output lsu_rdy, we3, a3, wd3, occ, fq_hit, fq_data
    );

endinterface

// File: rtl/ariscv_wbq_fifo.sv
// rtl/ariscv_wbq_fifo.sv - LSU result FIFO with kill-by-rd; youngest-match search under ARISCV_WBQ_FWD_EN
module ariscv_wbq_fifo
    import ariscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = PW + 1
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            push,
    input  wbq_ent_t        push_ent,
    input  logic            pop,
    input  logic            kill,
    input  logic [MSB:0]    kill_rd,
    output wbq_ent_t        head,
    output logic [OW-1:0]   occ
`ifdef ARISCV_WBQ_FWD_EN
    ,
    input  logic [MSB:0]    fq_a,
    output logic            fq_hit,
    output logic [REGW-1:0] fq_data
`endif
);

    wbq_ent_t      mem_q [DEPTH];
    wbq_ent_t      mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;

    // An entry landing on the same edge as a matching ALU write is older, so it is killed too.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill && (mem_q[i].rd == kill_rd)) begin
                mem_d[i].live = 1'b0;
            end
        end
        if (push) begin
            mem_d[wr_ptr_q]      = push_ent;
            mem_d[wr_ptr_q].live = push_ent.live && !(kill && (push_ent.rd == kill_rd));
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d    = occ_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign occ  = occ_q;

`ifdef ARISCV_WBQ_FWD_EN
    logic [PW-1:0] fq_idx;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fq_hit  = 1'b0;
        fq_data = '0;
        fq_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fq_idx = rd_ptr_q + PW'(k);
            if ((OW'(k) < occ_q) && mem_q[fq_idx].live && (mem_q[fq_idx].rd == fq_a)) begin
                fq_hit  = 1'b1;
                fq_data = mem_q[fq_idx].wd;
            end
        end
    end
`endif

endmodule

// File: rtl/ariscv_wbq.sv
// rtl/ariscv_wbq.sv - register-file writeback queue: ALU priority over buffered LSU results
// Optional load forwarding enabled by ARISCV_WBQ_FWD_EN.
module ariscv_wbq
    import ariscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        arst,
    ariscv_wbq_if.slave bus
);

    localparam int OW = $clog2(DEPTH) + 1;

    logic            alu_fire;
    logic            push;
    logic            pop;
    logic            lsu_rdy;
    logic [OW-1:0]   occ;
    wbq_ent_t        head;
    wbq_ent_t        push_ent;
    logic            we3_q, we3_d;
    logic [MSB:0]    a3_q, a3_d;
    logic [REGW-1:0] wd3_q, wd3_d;

    assign lsu_rdy  = occ < OW'(DEPTH);
    assign alu_fire = bus.alu_vld && (bus.alu_rd != ZERO);
    // x0 loads are acknowledged but never stored.
    assign push     = bus.lsu_vld && lsu_rdy && (bus.lsu_rd != ZERO);
    assign pop      = !alu_fire && (occ != '0);
    assign push_ent = {1'b1, bus.lsu_rd, bus.lsu_wd};

`ifdef ARISCV_WBQ_FWD_EN
    logic            fifo_hit;
    logic [REGW-1:0] fifo_data;
`endif

    ariscv_wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .arst     (arst),
        .push     (push),
        .push_ent (push_ent),
        .pop      (pop),
        .kill     (alu_fire),
        .kill_rd  (bus.alu_rd),
        .head     (head),
        .occ      (occ)
`ifdef ARISCV_WBQ_FWD_EN
        ,
        .fq_a     (bus.fq_a),
        .fq_hit   (fifo_hit),
        .fq_data  (fifo_data)
`endif
    );

    always_comb begin
        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (alu_fire) begin
            we3_d = 1'b1;
            a3_d  = bus.alu_rd;
            wd3_d = bus.alu_wd;
        end else if (pop) begin
            we3_d = head.live;
            a3_d  = head.rd;
            wd3_d = head.wd;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
        end
    end

    assign bus.we3     = we3_q;
    assign bus.a3      = a3_q;
    assign bus.wd3     = wd3_q;
    assign bus.occ     = occ;
    assign bus.lsu_rdy = lsu_rdy;

`ifdef ARISCV_WBQ_FWD_EN
    // Live queued loads are younger than the write on the port, so they take precedence.
    assign bus.fq_hit  = (bus.fq_a != ZERO) && (fifo_hit || (we3_q && (a3_q == bus.fq_a)));
    assign bus.fq_data = fifo_hit ? fifo_data : wd3_q;
`else
    logic unused_fq;
    assign unused_fq   = ^bus.fq_a;
    assign bus.fq_hit  = 1'b0;
    assign bus.fq_data = '0;
`endif

endmodule
